// File: rtl/pattern_vg2.sv
// Video test-pattern generator. Overlays or replaces the upstream pixel stream
// with a selectable pattern, with a fixed two-clock latency on all outputs.
module pattern_vg2 #(
   parameter int B               = 8,
   parameter int X_BITS          = 13,
   parameter int Y_BITS          = 13,
   parameter int FRACTIONAL_BITS = 1
) (
   input  logic                         clk_in,
   input  logic                         reset,
   input  logic [X_BITS-1:0]            x,
   input  logic [Y_BITS-1:0]            y,
   input  logic                         vn_in,
   input  logic                         hn_in,
   input  logic                         dn_in,
   input  logic [B-1:0]                 r_in,
   input  logic [B-1:0]                 g_in,
   input  logic [B-1:0]                 b_in,
   input  logic [X_BITS-1:0]            total_active_pix,
   input  logic [Y_BITS-1:0]            total_active_lines,
   input  logic [7:0]                   pattern,
   input  logic [B+FRACTIONAL_BITS-1:0] ramp_step,
   input  logic [X_BITS-1:0]            bar_width,
   input  logic [3:0]                   checker_shift,
   output logic                         vn_out,
   output logic                         hn_out,
   output logic                         den_out,
   output logic [B-1:0]                 r_out,
   output logic [B-1:0]                 g_out,
   output logic [B-1:0]                 b_out,
   output logic [7:0]                   active_pattern
);

   localparam int ACC_W = B + FRACTIONAL_BITS;
   localparam int PIPE_W = 3 * B + 3;

   typedef enum logic [7:0] {
      PAT_PASS    = 8'd0,
      PAT_BORDER  = 8'd1,
      PAT_MOIRE_X = 8'd2,
      PAT_MOIRE_Y = 8'd3,
      PAT_HRAMP   = 8'd4,
      PAT_VRAMP   = 8'd5,
      PAT_BARS    = 8'd6,
      PAT_CHECKER = 8'd7
   } pattern_t;

   logic [7:0]        active_q;
   logic              frame_start;
   logic [7:0]        cur_code;
   logic              x_first, x_last, y_first, y_last;

   logic [ACC_W-1:0]  h_acc, v_acc, h_val, v_val;
   logic [B-1:0]      h_pix, v_pix;

   logic [X_BITS-1:0] bar_cnt, bar_cnt_cur;
   logic [2:0]        bar_idx, bar_idx_cur;
   logic              bar_end;

   logic              x_cell, y_cell, cell_on;

   logic [B-1:0]      r_c, g_c, b_c;
   logic [PIPE_W-1:0] s1, s2;

   // The frame-start pixel already uses the newly requested code.
   assign frame_start = dn_in && (x == '0) && (y == '0);
   assign cur_code    = frame_start ? pattern : active_q;

   assign x_first = (x == '0);
   assign y_first = (y == '0);
   assign x_last  = (x == total_active_pix - X_BITS'(1));
   assign y_last  = (y == total_active_lines - Y_BITS'(1));

   assign h_val = x_first ? '0 : h_acc;
   assign v_val = y_first ? '0 : v_acc;
   assign h_pix = h_val[ACC_W-1:FRACTIONAL_BITS];
   assign v_pix = v_val[ACC_W-1:FRACTIONAL_BITS];

   assign bar_cnt_cur = x_first ? '0 : bar_cnt;
   assign bar_idx_cur = x_first ? '0 : bar_idx;
   assign bar_end     = (bar_cnt_cur == bar_width - X_BITS'(1));

   // Shifting the probe bit out of range yields 0 for oversized shifts.
   assign x_cell  = |(x & (X_BITS'(1) << checker_shift));
   assign y_cell  = |(y & (Y_BITS'(1) << checker_shift));
   assign cell_on = ~(x_cell ^ y_cell);

   always_comb begin
      r_c = r_in;
      g_c = g_in;
      b_c = b_in;
      if (!dn_in) begin
         if (cur_code inside {[PAT_MOIRE_X:PAT_CHECKER]}) begin
            r_c = '0;
            g_c = '0;
            b_c = '0;
         end
      end else begin
         case (cur_code)
            PAT_BORDER: begin
               if (x_first || y_first || x_last || y_last) begin
                  r_c = '1;
                  g_c = '1;
                  b_c = '1;
               end
            end
            PAT_MOIRE_X: begin
               r_c = {B{x[0]}};
               g_c = {B{x[0]}};
               b_c = {B{x[0]}};
            end
            PAT_MOIRE_Y: begin
               r_c = {B{y[0]}};
               g_c = {B{y[0]}};
               b_c = {B{y[0]}};
            end
            PAT_HRAMP: begin
               r_c = h_pix;
               g_c = h_pix;
               b_c = h_pix;
            end
            PAT_VRAMP: begin
               r_c = v_pix;
               g_c = v_pix;
               b_c = v_pix;
            end
            PAT_BARS: begin
               r_c = {B{~bar_idx_cur[1]}};
               g_c = {B{~bar_idx_cur[2]}};
               b_c = {B{~bar_idx_cur[0]}};
            end
            PAT_CHECKER: begin
               r_c = {B{cell_on}};
               g_c = {B{cell_on}};
               b_c = {B{cell_on}};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         active_q <= '0;
         h_acc    <= '0;
         v_acc    <= '0;
         bar_cnt  <= '0;
         bar_idx  <= '0;
         s1       <= '0;
         s2       <= '0;
      end else begin
         if (frame_start) active_q <= pattern;
         if (dn_in && cur_code == PAT_HRAMP) h_acc <= h_val + ramp_step;
         if (dn_in && cur_code == PAT_VRAMP && x_last) v_acc <= v_val + ramp_step;
         if (dn_in && cur_code == PAT_BARS) begin
            if (bar_end) begin
               bar_cnt <= '0;
               bar_idx <= (bar_idx_cur == 3'd7) ? 3'd7 : bar_idx_cur + 3'd1;
            end else begin
               bar_cnt <= bar_cnt_cur + X_BITS'(1);
               bar_idx <= bar_idx_cur;
            end
         end
         s1 <= {vn_in, hn_in, dn_in, r_c, g_c, b_c};
         s2 <= s1;
      end
   end

   assign {vn_out, hn_out, den_out, r_out, g_out, b_out} = s2;
   assign active_pattern = active_q;

endmodule

// File: tb/tb_pattern_vg2.sv
// Scoreboard bench for pattern_vg2: expected pixels are queued when driven and
// compared when they emerge two clocks later.
module tb_pattern_vg2;

   logic        clk_in = 1'b0;
   logic        reset;
   logic [12:0] x, total_active_pix, bar_width;
   logic [12:0] y, total_active_lines;
   logic        vn_in, hn_in, dn_in;
   logic [7:0]  r_in, g_in, b_in;
   logic [7:0]  pattern;
   logic [8:0]  ramp_step;
   logic [3:0]  checker_shift;
   logic        vn_out, hn_out, den_out;
   logic [7:0]  r_out, g_out, b_out, active_pattern;

   typedef struct {
      int          due;
      logic [26:0] val;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         edge_cnt = 0;
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] m_active = 8'd0;
   bit         ap_valid = 1'b0;

   logic [23:0] bar_colour [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                   24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   pattern_vg2 #(.B(8), .X_BITS(13), .Y_BITS(13), .FRACTIONAL_BITS(1)) dut (
      .clk_in(clk_in), .reset(reset), .x(x), .y(y),
      .vn_in(vn_in), .hn_in(hn_in), .dn_in(dn_in),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .total_active_pix(total_active_pix), .total_active_lines(total_active_lines),
      .pattern(pattern), .ramp_step(ramp_step), .bar_width(bar_width),
      .checker_shift(checker_shift),
      .vn_out(vn_out), .hn_out(hn_out), .den_out(den_out),
      .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .active_pattern(active_pattern)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) edge_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   always @(negedge clk_in) begin
      while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
         mon_e = sb.pop_front();
         check($sformatf("pix@%0d", mon_e.due),
               {5'd0, vn_out, hn_out, den_out, r_out, g_out, b_out}, {5'd0, mon_e.val});
      end
   end

   function automatic logic [23:0] model(input logic [7:0] code, input logic d,
                                         input int xv, input int yv, input logic [23:0] pix);
      int v, idx, cs, xb, yb;
      if (!d) return (code >= 8'd2 && code <= 8'd7) ? 24'h0 : pix;
      case (code)
         8'd1: return (xv == 0 || yv == 0 || xv == int'(total_active_pix) - 1 ||
                       yv == int'(total_active_lines) - 1) ? 24'hFFFFFF : pix;
         8'd2: return (xv % 2 == 1) ? 24'hFFFFFF : 24'h0;
         8'd3: return (yv % 2 == 1) ? 24'hFFFFFF : 24'h0;
         8'd4: begin
            v = ((xv * int'(ramp_step)) % 512) / 2;
            return {3{8'(v)}};
         end
         8'd5: begin
            v = ((yv * int'(ramp_step)) % 512) / 2;
            return {3{8'(v)}};
         end
         8'd6: begin
            idx = xv / int'(bar_width);
            if (idx > 7) idx = 7;
            return bar_colour[idx];
         end
         8'd7: begin
            cs = int'(checker_shift);
            xb = (cs >= 13) ? 0 : (xv >> cs) & 1;
            yb = (cs >= 13) ? 0 : (yv >> cs) & 1;
            return (xb == yb) ? 24'hFFFFFF : 24'h0;
         end
         default: return pix;
      endcase
   endfunction

   task automatic step(input logic rst_v, input logic vnv, input logic hnv, input logic dv,
                       input int xv, input int yv);
      logic [7:0]  code;
      logic [23:0] pix;
      exp_t        e;
      @(negedge clk_in);
      if (ap_valid) check("active_pattern", {24'd0, active_pattern}, {24'd0, m_active});
      pix   = 24'($urandom);
      reset = rst_v;
      vn_in = vnv;
      hn_in = hnv;
      dn_in = dv;
      x     = 13'(xv);
      y     = 13'(yv);
      {r_in, g_in, b_in} = pix;
      if (rst_v) begin
         while (sb.size() > 0 && sb[$].due > edge_cnt) void'(sb.pop_back());
         e.val = '0;
         e.due = edge_cnt + 1;
         sb.push_back(e);
         e.due = edge_cnt + 2;
         sb.push_back(e);
         m_active = 8'd0;
         ap_valid = 1'b1;
      end else begin
         code = (dv && xv == 0 && yv == 0) ? pattern : m_active;
         if (dv && xv == 0 && yv == 0) m_active = pattern;
         e.val = {vnv, hnv, dv, model(code, dv, xv, yv, pix)};
         e.due = edge_cnt + 2;
         sb.push_back(e);
      end
   endtask

   task automatic run_frame(input logic [7:0] pat, input int npix, input int nlines,
                            input int sw_x = -1, input int sw_y = -1, input logic [7:0] sw_pat = 8'd0,
                            input int rst_x = -1, input int rst_y = -1);
      total_active_pix   = 13'(npix);
      total_active_lines = 13'(nlines);
      pattern            = pat;
      step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      for (int yy = 0; yy < nlines; yy++) begin
         for (int xx = 0; xx < npix; xx++) begin
            if (xx == sw_x && yy == sw_y) pattern = sw_pat;
            if (xx == rst_x && yy == rst_y) step(1'b1, 1'b0, 1'b0, 1'b1, xx, yy);
            else step(1'b0, 1'b0, 1'b0, 1'b1, xx, yy);
         end
         for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0, npix - 1, yy);
      end
   endtask

   initial begin
      reset = 1'b1; vn_in = 1'b0; hn_in = 1'b0; dn_in = 1'b0;
      x = '0; y = '0; r_in = '0; g_in = '0; b_in = '0;
      total_active_pix = 13'd8; total_active_lines = 13'd4;
      pattern = 8'd0; ramp_step = 9'd2; bar_width = 13'd4; checker_shift = 4'd3;

      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

      run_frame(8'd0, 8, 3);
      run_frame(8'd1, 8, 4);
      run_frame(8'd2, 8, 2);
      run_frame(8'd3, 8, 4);
      ramp_step = 9'd2;  run_frame(8'd4, 32, 2);
      ramp_step = 9'd3;  run_frame(8'd4, 200, 2);
      ramp_step = 9'd4;  run_frame(8'd5, 4, 132);
      bar_width = 13'd4; run_frame(8'd6, 32, 2);
      bar_width = 13'd3; run_frame(8'd6, 32, 1);
      bar_width = 13'd1; run_frame(8'd6, 16, 1);
      checker_shift = 4'd3;  run_frame(8'd7, 16, 16);
      checker_shift = 4'd0;  run_frame(8'd7, 4, 4);
      checker_shift = 4'd13; run_frame(8'd7, 8, 2);
      run_frame(8'd9, 8, 2);
      run_frame(8'hFF, 4, 2);

      // Mid-frame request is ignored until the next frame start.
      checker_shift = 4'd3;
      run_frame(8'd0, 104, 51, 100, 50, 8'd7);
      run_frame(8'd7, 16, 16);

      // One-clock reset mid-frame: passthrough until the following frame.
      run_frame(8'd2, 16, 4, -1, -1, 8'd0, 5, 2);
      run_frame(8'd2, 16, 4);

      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_in);
      check("drain", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pattern_vg2.md
PATTERN_VG2 -- requirements
Module: pattern_vg2

Interface
REQ-001 SHALL have parameter B, default 8: bits per colour channel.
REQ-002 SHALL have parameter X_BITS, default 13: width of x and total_active_pix.
REQ-003 SHALL have parameter Y_BITS, default 13: width of y and total_active_lines.
REQ-004 SHALL have parameter FRACTIONAL_BITS, default 1: fractional bits of the ramp accumulators.
REQ-005 SHALL have port clk_in  input  1: pixel clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-007 SHALL have ports x, y  input  X_BITS, Y_BITS: active-pixel coordinates, valid while dn_in=1.
REQ-008 SHALL have ports vn_in, hn_in, dn_in  input  1 each: vsync, hsync, data enable.
REQ-009 SHALL have ports r_in, g_in, b_in  input  B each: upstream pixel.
REQ-010 SHALL have ports total_active_pix, total_active_lines  input  X_BITS, Y_BITS: active frame size.
REQ-011 SHALL have port pattern  input  8: requested pattern code.
REQ-012 SHALL have port ramp_step  input  B+FRACTIONAL_BITS: ramp increment.
REQ-013 SHALL have port bar_width  input  X_BITS: colour-bar width in pixels, legal range >=1.
REQ-014 SHALL have port checker_shift  input  4: checker cell edge = 2^checker_shift pixels.
REQ-015 SHALL have ports vn_out, hn_out, den_out  output  1 each: delayed syncs and enable.
REQ-016 SHALL have ports r_out, g_out, b_out  output  B each: output pixel.
REQ-017 SHALL have port active_pattern  output  8: pattern code currently in effect.

Function
REQ-018 SHALL have fixed latency of 2 clocks on all outputs: vn/hn/den and RGB for input cycle n appear at cycle n+2.
REQ-019 SHALL latch pattern into active_pattern only on the frame-start pixel (dn_in=1, x=0, y=0); that pixel and the rest of the frame use the new code; mid-frame changes of pattern are ignored.
REQ-020 SHALL use active_pattern codes: 0 passthrough; 1 white border over input; 2 moire X; 3 moire Y; 4 horizontal ramp; 5 vertical ramp; 6 colour bars; 7 checkerboard; any other code behaves as 0.
REQ-021 SHALL output zero RGB while dn_in=0 for codes 2-7; codes 0, 1 and undefined pass r/g/b_in through while dn_in=0.
REQ-022 Border: all channels all-ones when x=0, y=0, x=total_active_pix-1 or y=total_active_lines-1; otherwise input.
REQ-023 Moire X/Y: all-ones when x[0]=1 (resp. y[0]=1), else zero.
REQ-024 Horizontal ramp: accumulator loads ramp_step after pixel x=0 (output 0 at x=0), adds ramp_step each subsequent active pixel, wraps modulo 2^(B+FRACTIONAL_BITS); output = accumulator[B+FRACTIONAL_BITS-1:FRACTIONAL_BITS] on all channels.
REQ-025 Vertical ramp: separate accumulator, zero for line y=0, adds ramp_step once per line on the pixel x=total_active_pix-1, same wrap and output slice, constant across a line.
REQ-026 Colour bars: per-line bar counter and 3-bit bar index, both cleared at x=0; index increments when counter reaches bar_width-1, saturates at 7; index order white, yellow, cyan, green, magenta, red, blue, black with components all-ones or zero.
REQ-027 Checkerboard: all-ones when x[checker_shift] XOR y[checker_shift] = 0, else zero; checker_shift >= X_BITS or >= Y_BITS takes that bit as 0.
REQ-028 Accumulators and bar counters SHALL advance only on dn_in=1 and only while their pattern is active.

Reset
REQ-029 SHALL on reset clear active_pattern, both ramp accumulators, bar counter and index, all pipeline registers; vn_out, hn_out, den_out, r/g/b_out = 0 on the cycle after reset is sampled.
REQ-030 SHALL, after reset deasserts mid-frame, keep active_pattern=0 (passthrough) until the next frame-start pixel.

Verification
REQ-031 pattern=6, bar_width=4, 32-pixel line -> pixels 0-3 white (FF,FF,FF), 4-7 yellow (FF,FF,00), ..., 28-31 black, outputs 2 clocks after inputs.
REQ-032 pattern=4, B=8, FRACTIONAL_BITS=1, ramp_step=2 -> output 0,1,2,... per pixel; ramp_step=3 over 200 pixels -> accumulator wraps at 512, no glitch.
REQ-033 pattern switched 0->7 at x=100, y=50 -> output stays passthrough until next (0,0); checker_shift=3 -> 8x8 cells, pixel (8,0) zero, (8,8) FF.
REQ-034 pattern=5, ramp_step=4, FRACTIONAL_BITS=1 -> line y outputs 2*y (mod 256), constant across the line.
REQ-035 reset asserted mid-frame for one clock with pattern=2 -> all outputs 0 next cycle, passthrough until frame start, moire X resumes from the following frame.
